// File: rtl/fibonacci_scheduler.sv
// fibonacci_scheduler
// Shared Fibonacci engine behind a round-robin arbiter. One request is in
// flight at a time. The term is computed two Fibonacci steps per cycle, and
// the result is returned with the requester id and an overflow flag over a
// valid/ready channel.

module fibonacci_scheduler #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 8,
   parameter int W     = 16,
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*IDX_W-1:0] req_index,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [W-1:0]           resp_data,
   output logic [ID_W-1:0]        resp_id,
   output logic                   resp_ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;

   // Arbiter
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   grant_idx;
   logic              grant_found;
   logic [N_REQ-1:0]  grant_oh;
   logic [ID_W:0]     scan;
   logic [ID_W-1:0]   scan_id;
   logic [ID_W-1:0]   ptr_after;
   logic              accept;
   logic [IDX_W-1:0]  k_sel;

   // Datapath: a holds F(n), b holds F(n+1)
   logic [W-1:0]      a;
   logic [W-1:0]      b;
   logic [IDX_W-1:0]  rem;
   logic [ID_W-1:0]   id;
   logic              ovf_a;
   logic              ovf_b;
   logic [W:0]        sum_ab;
   logic [W:0]        sum_a2b;

   // Unsigned add that keeps the carry in the top bit
   function automatic logic [W:0] add_c(input logic [W-1:0] x, input logic [W-1:0] y);
      return {1'b0, x} + {1'b0, y};
   endfunction

   // Pointer value that follows the granted requester, wrapping at N_REQ
   function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] g);
      logic [ID_W-1:0] r;
      if (g == ID_W'(N_REQ - 1)) r = '0;
      else                       r = g + ID_W'(1);
      return r;
   endfunction

   // Round-robin search: first valid requester at or above rr_ptr, with wrap
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      grant_oh    = '0;
      scan        = '0;
      scan_id     = '0;
      for (int j = 0; j < N_REQ; j++) begin
         scan = {1'b0, rr_ptr} + (ID_W+1)'(j);
         if (scan >= (ID_W+1)'(N_REQ)) scan = scan - (ID_W+1)'(N_REQ);
         scan_id = scan[ID_W-1:0];
         if (!grant_found && req_valid[scan_id]) begin
            grant_found       = 1'b1;
            grant_idx         = scan_id;
            grant_oh[scan_id] = 1'b1;
         end
      end
   end

   assign req_ready = (state == IDLE) ? grant_oh : '0;
   assign accept    = (state == IDLE) && grant_found;
   assign k_sel     = req_index[grant_idx*IDX_W +: IDX_W];
   assign ptr_after = next_ptr(grant_idx);

   // Two chained adders: a+b, then (a+b)+b = a+2b
   always_comb begin
      sum_ab  = add_c(a, b);
      sum_a2b = add_c(sum_ab[W-1:0], b);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: leave BUSY on the step that brings rem to zero
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) state_nxt = (k_sel == '0) ? RESP : BUSY;
         end
         BUSY: begin
            if (rem <= IDX_W'(2)) state_nxt = RESP;
         end
         RESP: begin
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Arbiter pointer and granted id, updated on acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
         id     <= '0;
      end else if (accept) begin
         rr_ptr <= ptr_after;
         id     <= grant_idx;
      end
   end

   // Fibonacci datapath: seed on accept, then two terms (or one) per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a     <= '0;
         b     <= '0;
         rem   <= '0;
         ovf_a <= 1'b0;
         ovf_b <= 1'b0;
      end else if (accept) begin
         a     <= W'(1);
         b     <= W'(1);
         rem   <= k_sel;
         ovf_a <= 1'b0;
         ovf_b <= 1'b0;
      end else if (state == BUSY) begin
         if (rem >= IDX_W'(2)) begin
            a     <= sum_ab[W-1:0];
            b     <= sum_a2b[W-1:0];
            rem   <= rem - IDX_W'(2);
            ovf_a <= sum_ab[W] | ovf_a | ovf_b;
            ovf_b <= sum_ab[W] | sum_a2b[W] | ovf_a | ovf_b;
         end else if (rem == IDX_W'(1)) begin
            a     <= b;
            b     <= sum_ab[W-1:0];
            rem   <= '0;
            ovf_a <= ovf_b;
            ovf_b <= sum_ab[W] | ovf_a | ovf_b;
         end
      end
   end

   // Response outputs come straight from held registers, so they are stable in RESP
   assign resp_valid = (state == RESP);
   assign resp_data  = a;
   assign resp_id    = id;
   assign resp_ovf   = ovf_a;

endmodule

// File: tb/tb_fibonacci_scheduler.sv
// Testbench for fibonacci_scheduler: directed phases plus randomized traffic,
// checked by a scoreboard fed from a behavioural Fibonacci/arbiter model.

module tb_fibonacci_scheduler;

   localparam int N_REQ = 4;
   localparam int IDX_W = 8;
   localparam int W     = 16;
   localparam int ID_W  = 2;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [N_REQ-1:0]       req_valid = '0;
   logic [N_REQ*IDX_W-1:0] req_index = '0;
   logic [N_REQ-1:0]       req_ready;
   logic                   resp_valid;
   logic                   resp_ready = 1'b1;
   logic [W-1:0]           resp_data;
   logic [ID_W-1:0]        resp_id;
   logic                   resp_ovf;

   fibonacci_scheduler #(.N_REQ(N_REQ), .IDX_W(IDX_W), .W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_index  (req_index),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id),
      .resp_ovf   (resp_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           id;
      logic [W-1:0] data;
      bit           ovf;
      int           k;
   } exp_t;

   exp_t    sbq[$];
   int      grant_log[$];
   int      errors = 0;
   int      checks = 0;
   longint  cyc = 0;
   bit      in_flight = 0;
   bit      seen_valid = 0;
   int      rr_exp = 0;
   longint  acc_cyc = 0;
   int      cur_k = 0;
   bit      done = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: F(0)=F(1)=1, single-step recurrence, true value saturated at 2^W
   function automatic void fib_ref(input int k, output logic [W-1:0] v, output bit ovf);
      logic [W-1:0] m0, m1, m2;
      longint       t0, t1, t2, lim;
      m0 = 1; m1 = 1; t0 = 1; t1 = 1;
      lim = longint'(1) << W;
      for (int n = 2; n <= k; n++) begin
         m2 = m0 + m1;
         t2 = t0 + t1;
         if (t2 > lim) t2 = lim;
         m0 = m1; m1 = m2;
         t0 = t1; t1 = t2;
      end
      v   = (k == 0) ? m0 : m1;
      ovf = (((k == 0) ? t0 : t1) >= lim);
   endfunction

   // Reference arbiter: first valid requester from ptr upward, wrapping
   function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] v, input int ptr);
      logic [N_REQ-1:0] r;
      r = '0;
      for (int j = 0; j < N_REQ; j++) begin
         int i;
         i = (ptr + j) % N_REQ;
         if (v[i] && r == '0) r[i] = 1'b1;
      end
      return r;
   endfunction

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Monitor: sampled mid-cycle, inputs change only just after posedge
   always @(negedge clk) begin
      if (!rst_n) begin
         sbq.delete();
         in_flight  = 0;
         seen_valid = 0;
         rr_exp     = 0;
      end else begin
         logic [N_REQ-1:0] exp_rdy;
         logic [N_REQ-1:0] acc;
         exp_rdy = in_flight ? '0 : rr_pick(req_valid, rr_exp);
         checks++;
         if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL req_ready: got %b expected %b (t=%0t)", req_ready, exp_rdy, $time);
         end
         if (resp_valid) begin
            if (sbq.size() == 0) begin
               checks++; errors++;
               $display("FAIL spurious_resp: got resp_valid=1 expected 0 (t=%0t)", $time);
            end else begin
               exp_t e;
               e = sbq[0];
               checks++;
               if (resp_data !== e.data || resp_ovf !== e.ovf || int'(resp_id) != e.id) begin
                  errors++;
                  $display("FAIL resp k=%0d: got data=%0d ovf=%0b id=%0d expected data=%0d ovf=%0b id=%0d",
                           e.k, resp_data, resp_ovf, resp_id, e.data, e.ovf, e.id);
               end
               if (!seen_valid) begin
                  seen_valid = 1;
                  checks++;
                  if (cyc - acc_cyc - 1 != longint'((cur_k + 1) / 2)) begin
                     errors++;
                     $display("FAIL latency k=%0d: got %0d expected %0d", cur_k,
                              cyc - acc_cyc - 1, (cur_k + 1) / 2);
                  end
               end
               if (resp_ready) begin
                  void'(sbq.pop_front());
                  in_flight  = 0;
                  seen_valid = 0;
               end
            end
         end
         acc = req_valid & req_ready;
         if (acc != '0) begin
            exp_t e;
            int   g;
            g = 0;
            for (int i = N_REQ - 1; i >= 0; i--) if (acc[i]) g = i;
            e.id = g;
            e.k  = int'(req_index[g*IDX_W +: IDX_W]);
            fib_ref(e.k, e.data, e.ovf);
            sbq.push_back(e);
            grant_log.push_back(g);
            in_flight = 1;
            cur_k     = e.k;
            acc_cyc   = cyc;
            rr_exp    = (g + 1) % N_REQ;
         end
      end
   end

   // Raise a request and hold it until granted, then drop it
   task automatic issue(input int i, input int k);
      bit got;
      got = 0;
      @(posedge clk); #2;
      req_valid[i] = 1'b1;
      req_index[i*IDX_W +: IDX_W] = IDX_W'(k);
      for (int c = 0; c < 3000 && !got; c++) begin
         @(negedge clk);
         if (req_ready[i]) got = 1;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL grant_timeout req=%0d: got no grant expected grant", i);
      end
      @(posedge clk); #2;
      req_valid[i] = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int c = 0; c < 3000 && !ok; c++) begin
         @(negedge clk);
         if (!in_flight && sbq.size() == 0) ok = 1;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #3;
      rst_n = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b1;
   endtask

   task automatic rand_req(input int i);
      repeat (6) begin
         int k;
         repeat ($urandom_range(0, 5)) @(posedge clk);
         k = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 60));
         issue(i, k);
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      int bp_k[4];
      // Reset state
      #1;
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data",  resp_data, 0);
      chk("rst_resp_id",    resp_id, 0);
      chk("rst_resp_ovf",   resp_ovf, 0);
      chk("rst_req_ready",  req_ready, 0);
      @(posedge clk); #3;
      rst_n = 1'b1;

      // Basic request: k=10 -> 89
      issue(0, 10);
      wait_idle();

      // Sweep 0..23 from requester 2
      for (int k = 0; k <= 23; k++) issue(2, k);
      wait_idle();

      // Overflow boundary
      bp_k = '{23, 24, 25, 255};
      foreach (bp_k[n]) issue(1, bp_k[n]);
      wait_idle();

      // Fairness: all four valid together from rr_ptr=0
      do_reset();
      start = grant_log.size();
      fork
         begin issue(0, 7);  issue(0, 8);  end
         begin issue(1, 11); issue(1, 12); end
         begin issue(2, 14); issue(2, 15); end
         begin issue(3, 20); issue(3, 21); end
      join
      wait_idle();
      for (int n = 0; n < 5; n++)
         chk($sformatf("rr_order[%0d]", n),
             (grant_log.size() > start + n) ? grant_log[start + n] : -1, n % N_REQ);

      // Back-pressure: response held for 20 cycles, a competing request waits
      @(posedge clk); #2;
      resp_ready = 1'b0;
      issue(1, 20);
      fork
         issue(3, 4);
      join_none
      for (int c = 0; c < 100 && !resp_valid; c++) @(negedge clk);
      chk("bp_valid", resp_valid, 1);
      repeat (20) @(posedge clk);
      #2;
      chk("bp_still_valid", resp_valid, 1);
      resp_ready = 1'b1;
      wait fork;
      wait_idle();

      // Asynchronous reset mid-BUSY
      issue(2, 200);
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_resp_valid", resp_valid, 0);
      chk("arst_req_ready",  req_ready, 0);
      chk("arst_resp_data",  resp_data, 0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      repeat (120) @(posedge clk);
      start = grant_log.size();
      fork
         issue(1, 5);
         issue(3, 5);
      join
      wait_idle();
      chk("arst_first_grant",  (grant_log.size() > start) ? grant_log[start] : -1, 1);
      chk("arst_second_grant", (grant_log.size() > start + 1) ? grant_log[start + 1] : -1, 3);

      // Randomized traffic with random back-pressure
      done = 0;
      fork
         while (!done) begin
            @(posedge clk); #2;
            resp_ready = ($urandom_range(0, 3) != 0);
         end
      join_none
      fork
         rand_req(0);
         rand_req(1);
         rand_req(2);
         rand_req(3);
      join
      done = 1;
      repeat (2) @(posedge clk);
      #2;
      resp_ready = 1'b1;
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fibonacci_scheduler.md
# fibonacci_scheduler

Shared Fibonacci compute engine with a round-robin front end. Up to N_REQ requesters each ask for the k-th term of the sequence 1, 1, 2, 3, 5, … (F(0)=F(1)=1). The block grants one request at a time and computes the term on an internal double-rate datapath that advances two terms per cycle. It returns the result, the requester id and an overflow flag over a valid/ready response channel. It sits between the sequence generators and their consumers, so one adder pair serves all clients.

## Interface
Parameters:
- N_REQ, 4: number of requesters, ≥2
- IDX_W, 8: width of the requested index k
- W, 16: datapath and result width; arithmetic is mod 2^W
- ID_W, $clog2(N_REQ): width of resp_id (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  request pending, one bit per requester
- req_index  in  N_REQ*IDX_W  packed indices; requester i uses bits [i*IDX_W +: IDX_W]
- req_ready  out  N_REQ  one-hot grant; combinational; all zero unless state is IDLE
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts the result
- resp_data  out  W  F(k) mod 2^W
- resp_id  out  ID_W  index of the granted requester
- resp_ovf  out  1  1 if the true F(k) ≥ 2^W

## Operation
The block has three states: IDLE, BUSY and RESP.

**IDLE**
- req_ready = one-hot of the first set req_valid bit, searching from rr_ptr upward with wrap-around.
- On acceptance (req_valid[i] & req_ready[i] at the edge): latch id = i, a = 1, b = 1, rem = k, ovf_a = ovf_b = 0, and set rr_ptr = (i+1) mod N_REQ.
- If k == 0, go to RESP; otherwise go to BUSY.

**BUSY** (one step per cycle)
- rem ≥ 2: a ← a+b, b ← a+2b, rem ← rem−2.
  - ovf_a ← carry(a+b) | ovf_a | ovf_b
  - ovf_b ← carry out of either adder in a+2b | ovf_a | ovf_b
- rem == 1: a ← b, b ← a+b, rem ← 0.
  - ovf_a ← ovf_b
  - ovf_b ← carry | ovf_a | ovf_b
- The state goes to RESP on the edge where rem becomes 0.

**RESP**
- resp_valid = 1; resp_data = a, resp_ovf = ovf_a, resp_id = id.
- All response outputs are held stable until resp_valid & resp_ready at an edge, then the state goes to IDLE.

**General rules**
- Only one request is in flight; requesters hold req_valid and req_index until granted.
- Dropping req_valid before grant is legal. The block has no memory of un-granted requests.
- req_index is sampled only on the accept edge; changes afterwards have no effect.

## Timing
- **Reset (rst_n low, asynchronous):**
  - state = IDLE, rr_ptr = 0, a = b = 0, rem = 0, id = 0, ovf_a = ovf_b = 0
  - resp_valid = 0, resp_data = 0, resp_id = 0, resp_ovf = 0, req_ready = 0 (no requests pending)
  - Reset mid-BUSY or mid-RESP drops the in-flight request; no response is produced.
- **Latency:** accept at edge E0 → resp_valid high after edge E0 + ceil(k/2).
  - k = 0: high after E0 itself.
- **Throughput:** resp_valid rises → the next grant is possible no earlier than the cycle after the resp_valid & resp_ready edge (one-cycle bubble). resp_ready held high gives one request per ceil(k/2) + 2 cycles.
- **Back-pressure:** resp_ready low holds RESP indefinitely; req_ready stays 0.
- **Simultaneous requests:** exactly one grant per IDLE cycle. With all requesters always valid, the grant order is 0, 1, 2, 3, 0, … (starvation-free).
- **Index wrap:** k up to 2^IDX_W − 1 is legal; results wrap mod 2^W with resp_ovf = 1.

## Test plan
- **Basic request:** reset, then requester 0 asks k=10 → resp_data=89, resp_id=0, resp_ovf=0; resp_valid rises 5 cycles after the accept edge.
- **Small indices:** k = 0, 1, 2, 3 from requester 2 → resp_data = 1, 1, 2, 3.
  - k=0 and k=1 each need one cycle or fewer of BUSY; k=0 skips BUSY.
  - Compare a sweep of k = 0..23 against a reference model.
- **Overflow boundary:**
  - k=23 → 46368, ovf=0.
  - k=24 → 9489, ovf=1.
  - k=25 → 55857 (121393 mod 65536), ovf=1.
  - k=255 → the model value mod 2^16, ovf=1.
- **Round-robin fairness:** all four requesters assert valid continuously with distinct k → grants in order 0, 1, 2, 3, 0; each resp_id matches its data.
- **Back-pressure:** hold resp_ready low for 20 cycles in RESP → resp_valid/data/id/ovf remain stable, req_ready = 0 throughout; release → one transfer, then IDLE.
- **Asynchronous reset mid-operation:** assert rst_n low between clock edges during BUSY for k=200 → resp_valid and req_ready drop immediately, no stale response after release, and the next request (k=5 → 8) is served from rr_ptr=0.
